regfile_wb_arbiter: RTL and testbench

Shares the single register-file write port between the pipeline WriteBack stage and one auxiliary long-latency producer (multiply/divide unit, load-miss return). WriteBack has priority. Aux results are held in a one-entry buffer and written on the first free port cycle. If the aux entry waits MAX_WAIT cycles, the block stalls the pipeline for one cycle to force the write. It exports a pending-destination mask for the hazard unit.

---
 rtl/regfile_wb_arbiter.sv | 158 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: WriteBack has priority, one auxiliary
// result is parked in a single-entry buffer until the port is free. An entry
// blocked for MAX_WAIT cycles forces its write by stalling the pipeline once.
//
//   state | meaning
//   IDLE  | buffer empty, aux results accepted
//   HELD  | one aux entry waiting for a free port cycle
//   FORCE | forced aux write, pipeline stalled this cycle
module regfile_wb_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_WAIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pipe_we,
    input  logic [ADDR_W-1:0]    pipe_rd,
    input  logic [DATA_W-1:0]    pipe_data,
    output logic                 pipe_stall,
    input  logic                 aux_valid,
    output logic                 aux_ready,
    input  logic [ADDR_W-1:0]    aux_rd,
    input  logic [DATA_W-1:0]    aux_data,
    input  logic                 aux_flush,
    output logic                 rf_we,
    output logic [ADDR_W-1:0]    rf_rd,
    output logic [DATA_W-1:0]    rf_data,
    output logic [2**ADDR_W-1:0] pending_mask,
    output logic                 waw_drop,
    output logic                 busy
);

    localparam int NREG  = 2**ADDR_W;
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HELD  = 2'd1,
        FORCE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_buf_rd;
    logic [DATA_W-1:0]   r_buf_data;
    logic [CNT_W-1:0]    r_wait_cnt;
    logic [NREG-1:0]     r_pending_mask;
    logic                r_waw_drop;

    logic                w_port_free;
    logic                w_hit;
    logic                w_latch;
    logic                w_sel_buf;
    logic                w_stall;
    logic                w_clear;
    logic                w_waw;
    logic                w_cnt_inc;
    logic [NREG-1:0]     w_aux_onehot;
    logic [NREG-1:0]     w_buf_onehot;

    assign w_port_free  = !pipe_we || (pipe_rd == '0);
    assign w_hit        = pipe_we && (pipe_rd == r_buf_rd);
    // A zero-destination aux result is accepted but never buffered.
    assign w_latch      = (r_state == IDLE) && aux_valid && (aux_rd != '0);
    assign w_aux_onehot = {{(NREG-1){1'b0}}, 1'b1} << aux_rd;
    assign w_buf_onehot = {{(NREG-1){1'b0}}, 1'b1} << r_buf_rd;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and port-select decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_buf   = 1'b0;
        w_stall     = 1'b0;
        w_clear     = 1'b0;
        w_waw       = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_latch) begin
                    w_state_nxt = HELD;
                end
            end
            HELD: begin
                if (aux_flush) begin
                    w_clear     = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_hit) begin
                    // Younger pipe write to the same register makes the entry dead.
                    w_clear     = 1'b1;
                    w_waw       = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_port_free) begin
                    w_sel_buf   = 1'b1;
                    w_clear     = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_inc = 1'b1;
                    if (r_wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
                        w_state_nxt = FORCE;
                    end
                end
            end
            FORCE: begin
                w_clear     = 1'b1;
                w_state_nxt = IDLE;
                if (!aux_flush) begin
                    w_sel_buf = 1'b1;
                    w_stall   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Buffer, wait counter, pending mask and supersede pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_rd       <= '0;
            r_buf_data     <= '0;
            r_wait_cnt     <= '0;
            r_pending_mask <= '0;
            r_waw_drop     <= 1'b0;
        end else begin
            r_waw_drop <= w_waw;
            if (w_latch) begin
                r_buf_rd       <= aux_rd;
                r_buf_data     <= aux_data;
                r_wait_cnt     <= '0;
                r_pending_mask <= r_pending_mask | w_aux_onehot;
            end else if (w_clear) begin
                r_pending_mask <= r_pending_mask & ~w_buf_onehot;
            end else if (w_cnt_inc) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end
    end

    // Outputs are held quiet while reset is asserted.
    assign rf_we        = rst_n && (w_sel_buf || (pipe_we && (pipe_rd != '0)));
    assign rf_rd        = w_sel_buf ? r_buf_rd   : pipe_rd;
    assign rf_data      = w_sel_buf ? r_buf_data : pipe_data;
    assign pipe_stall   = rst_n && w_stall;
    assign aux_ready    = rst_n && (r_state == IDLE);
    assign pending_mask = r_pending_mask;
    assign waw_drop     = r_waw_drop;
    assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed stimulus, a per-cycle reference model
// of the one-entry aux buffer, and literal checks at key points.
module tb_regfile_wb_arbiter;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              pipe_we;
    logic [ADDR_W-1:0] pipe_rd;
    logic [DATA_W-1:0] pipe_data;
    logic              pipe_stall;
    logic              aux_valid;
    logic              aux_ready;
    logic [ADDR_W-1:0] aux_rd;
    logic [DATA_W-1:0] aux_data;
    logic              aux_flush;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_rd;
    logic [DATA_W-1:0] rf_data;
    logic [31:0]       pending_mask;
    logic              waw_drop;
    logic              busy;

    int n_checks = 0;
    int n_pass   = 0;

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data), .pipe_stall(pipe_stall),
        .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_rd(aux_rd), .aux_data(aux_data),
        .aux_flush(aux_flush), .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data),
        .pending_mask(pending_mask), .waw_drop(waw_drop), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    endtask

    // Reference model: an entry is either present or not, with a count of
    // cycles it has been blocked by pipe writes.
    bit          m_has = 1'b0;
    int          m_rd = 0;
    logic [31:0] m_data = '0;
    int          m_blocked = 0;
    bit          m_waw = 1'b0;

    bit          e_forcing, e_hit, e_aux_wr, e_pipe_eff, e_stall, e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_data, e_mask;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_rf_we", rf_we, 0);
            chk("rst_stall", pipe_stall, 0);
            chk("rst_ready", aux_ready, 0);
            chk("rst_mask", pending_mask, 0);
            chk("rst_waw", waw_drop, 0);
            m_has = 0; m_waw = 0; m_blocked = 0;
        end else begin
            e_forcing  = m_has && (m_blocked >= MAX_WAIT);
            e_hit      = m_has && !e_forcing && !aux_flush && pipe_we && (int'(pipe_rd) == m_rd);
            e_pipe_eff = pipe_we && (pipe_rd != 0);
            e_stall    = e_forcing && !aux_flush;
            e_aux_wr   = e_stall || (m_has && !e_forcing && !aux_flush && !e_hit && !e_pipe_eff);
            e_we       = e_aux_wr || e_pipe_eff;
            e_rd       = e_aux_wr ? 5'(m_rd) : pipe_rd;
            e_data     = e_aux_wr ? m_data : pipe_data;
            e_mask     = m_has ? (32'h1 << m_rd) : 32'h0;
            chk("rf_we", rf_we, e_we);
            if (e_we) begin
                chk("rf_rd", rf_rd, e_rd);
                chk("rf_data", rf_data, e_data);
            end
            chk("pipe_stall", pipe_stall, e_stall);
            chk("aux_ready", aux_ready, !m_has);
            chk("busy", busy, m_has);
            chk("pending_mask", pending_mask, e_mask);
            chk("waw_drop", waw_drop, m_waw);
            m_waw = e_hit;
            if (m_has) begin
                if (e_forcing || aux_flush || e_hit || e_aux_wr) m_has = 0;
                else m_blocked++;
            end else if (aux_valid && aux_rd != 0) begin
                m_has = 1; m_rd = int'(aux_rd); m_data = aux_data; m_blocked = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        pipe_we = 0; pipe_rd = '0; pipe_data = '0;
        aux_valid = 0; aux_rd = '0; aux_data = '0; aux_flush = 0;
    endtask

    task automatic offer_aux(input logic [4:0] rd, input logic [31:0] d);
        aux_valid = 1; aux_rd = rd; aux_data = d;
        tick();
        aux_valid = 0;
    endtask

    task automatic pipe_wr(input logic [4:0] rd, input logic [31:0] d);
        pipe_we = 1; pipe_rd = rd; pipe_data = d;
    endtask

    initial begin
        rst_n = 0;
        quiet();
        tick(); tick();
        rst_n = 1;
        tick();

        // Accept x5 with the port free: written the very next cycle.
        aux_valid = 1; aux_rd = 5'd5; aux_data = 32'hDEADBEEF;
        #2 chk("A_ready", aux_ready, 1);
        tick();
        aux_valid = 0;
        #2 chk("A_we", rf_we, 1);
        chk("A_rd", rf_rd, 5);
        chk("A_data", rf_data, 32'hDEADBEEF);
        chk("A_mask", pending_mask, 32'h20);
        tick();
        #2 chk("A_mask_clr", pending_mask, 0);
        chk("A_busy", busy, 0);

        // x9 blocked four cycles, then forced; the stalled pipe write re-presents.
        tick();
        offer_aux(5'd9, 32'h99);
        pipe_wr(5'd3, 32'h3); tick();
        pipe_wr(5'd4, 32'h4); tick();
        pipe_wr(5'd6, 32'h6); tick();
        pipe_wr(5'd8, 32'h8); tick();
        pipe_wr(5'd10, 32'hA);
        #2 chk("B_stall", pipe_stall, 1);
        chk("B_rd", rf_rd, 9);
        chk("B_data", rf_data, 32'h99);
        tick();
        #2 chk("B_stall_off", pipe_stall, 0);
        chk("B_rd_pipe", rf_rd, 10);
        chk("B_we_pipe", rf_we, 1);
        tick();
        quiet();

        // Pipe write to x12 supersedes the buffered x12.
        offer_aux(5'd12, 32'h12);
        pipe_wr(5'd12, 32'h1);
        #2 chk("C_rd", rf_rd, 12);
        chk("C_data", rf_data, 32'h1);
        tick();
        quiet();
        #2 chk("C_waw", waw_drop, 1);
        chk("C_mask", pending_mask, 0);
        chk("C_we", rf_we, 0);
        tick();
        #2 chk("C_waw_low", waw_drop, 0);

        // Flush while HELD.
        offer_aux(5'd7, 32'h7);
        aux_flush = 1; pipe_wr(5'd2, 32'h22);
        #2 chk("D_rd", rf_rd, 2);
        chk("D_data", rf_data, 32'h22);
        chk("D_stall", pipe_stall, 0);
        tick();
        quiet();
        #2 chk("D_busy", busy, 0);
        chk("D_ready", aux_ready, 1);
        tick();

        // Flush during the forced-write cycle.
        offer_aux(5'd7, 32'h77);
        pipe_wr(5'd3, 32'h3); tick();
        pipe_wr(5'd4, 32'h4); tick();
        pipe_wr(5'd6, 32'h6); tick();
        pipe_wr(5'd8, 32'h8); tick();
        aux_flush = 1; pipe_wr(5'd2, 32'h22);
        #2 chk("E_stall", pipe_stall, 0);
        chk("E_rd", rf_rd, 2);
        chk("E_we", rf_we, 1);
        tick();
        quiet();
        #2 chk("E_busy", busy, 0);
        tick();

        // Zero destination: accepted and discarded; pipe write to x0 leaves the port free.
        aux_valid = 1; aux_rd = 5'd0; aux_data = 32'h5;
        #2 chk("F_ready", aux_ready, 1);
        tick();
        aux_valid = 0;
        #2 chk("F_busy", busy, 0);
        chk("F_mask", pending_mask, 0);
        tick();
        offer_aux(5'd14, 32'hE);
        pipe_wr(5'd0, 32'h55);
        #2 chk("F_we", rf_we, 1);
        chk("F_rd", rf_rd, 14);
        chk("F_data", rf_data, 32'hE);
        tick();
        quiet();
        tick();

        // Back-to-back offers: second waits until the buffer drains.
        aux_valid = 1; aux_rd = 5'd20; aux_data = 32'h20;
        tick();
        aux_rd = 5'd21; aux_data = 32'h21;
        tick(); tick();
        quiet();
        tick(); tick();

        // Reset while an entry is held.
        offer_aux(5'd7, 32'h7);
        pipe_wr(5'd3, 32'h3);
        #1 chk("G_mask_pre", pending_mask, 32'h80);
        rst_n = 0;
        #1 chk("G_mask", pending_mask, 0);
        chk("G_we", rf_we, 0);
        chk("G_ready", aux_ready, 0);
        tick(); tick();
        quiet();
        rst_n = 1;
        tick();
        #2 chk("G_ready_post", aux_ready, 1);
        chk("G_busy_post", busy, 0);
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
